// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 set-2 keyboard scan controller:
// prefix bytes and the receive-handshake state encoding.
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational set-2 scan code to lowercase ASCII lookup.
// Covers letters, digits, space and enter; everything else maps to 0x00.
module kbd_scan2ascii (
  input  logic [7:0] scan_code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (scan_code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Pops scan bytes from a keyboard receiver FIFO, assembles E0/F0-prefixed
// key events, tracks the single held key and counts fresh make events.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_repeat,
  output logic             key_held,
  output logic [7:0]       ascii,
  output logic [CNT_W-1:0] key_count,
  output logic             err_ovf
);

  scan_state_e      state_q, state_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             held_q, held_d;
  logic             held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] key_count_q, key_count_d;
  logic             err_ovf_q, err_ovf_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_break_q, key_break_d;
  logic             key_repeat_q, key_repeat_d;
  logic             key_valid_q, key_valid_d;
  logic             key_match;
  logic [7:0]       lut_ascii;

  assign key_match = held_q && (held_ext_q == ext_q) && (held_code_q == kb_data);

  always_comb begin
    state_d      = state_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    held_d       = held_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    key_count_d  = key_count_q;
    err_ovf_d    = err_ovf_q | kb_overflow;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    key_repeat_d = key_repeat_q;
    key_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (kb_ready) begin
          state_d = ST_ACK;
          case (kb_data)
            SC_EXT:   ext_d = 1'b1;
            SC_BRK:   brk_d = 1'b1;
            SC_PAUSE: ;
            default: begin
              key_code_d  = kb_data;
              key_ext_d   = ext_q;
              key_break_d = brk_q;
              key_valid_d = 1'b1;
              ext_d       = 1'b0;
              brk_d       = 1'b0;
              // A release only forgets the held key if it names that key.
              if (brk_q) begin
                key_repeat_d = 1'b0;
                if (key_match) held_d = 1'b0;
              end else if (key_match) begin
                key_repeat_d = 1'b1;
              end else begin
                key_repeat_d = 1'b0;
                held_d       = 1'b1;
                held_ext_d   = ext_q;
                held_code_d  = kb_data;
                key_count_d  = key_count_q + CNT_W'(1);
              end
            end
          endcase
        end
      end
      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      key_count_q  <= '0;
      err_ovf_q    <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      held_q       <= held_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      key_count_q  <= key_count_d;
      err_ovf_q    <= err_ovf_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_repeat_q <= key_repeat_d;
      key_valid_q  <= key_valid_d;
    end
  end

  kbd_scan2ascii u_scan2ascii (
    .scan_code (held_code_q),
    .ascii     (lut_ascii)
  );

  // Extended keys (arrows, keypad enter, ...) never produce ASCII.
  assign ascii         = (held_q && !held_ext_q) ? lut_ascii : 8'h00;
  assign kb_nextdata_n = (state_q != ST_ACK);
  assign key_valid     = key_valid_q;
  assign key_code      = key_code_q;
  assign key_ext       = key_ext_q;
  assign key_break     = key_break_q;
  assign key_repeat    = key_repeat_q;
  assign key_held      = held_q;
  assign key_count     = key_count_q;
  assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Self-checking bench for kbd_scan_ctrl: a queue-based receiver FIFO feeds
// scan bytes, and an event-level model predicts every key event.
module tb_kbd_scan_ctrl;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       held;
    logic [7:0] asc;
    int         count;
  } ev_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;

  logic       kb_nextdata_n, key_valid, key_ext, key_break, key_repeat, key_held, err_ovf;
  logic [7:0] key_code, ascii, key_count;
  logic       kb_nextdata_n2, key_valid2, key_ext2, key_break2, key_repeat2, key_held2, err_ovf2;
  logic [7:0] key_code2, ascii2;
  logic [1:0] key_count2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] fifo[$];
  ev_t        exp_q[$];

  logic       m_ext, m_brk, m_held, m_hext;
  logic [7:0] m_hcode;
  int         m_count;
  logic       prev_valid = 1'b0;

  kbd_scan_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_repeat(key_repeat), .key_held(key_held),
    .ascii(ascii), .key_count(key_count), .err_ovf(err_ovf)
  );

  kbd_scan_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n2),
    .key_valid(key_valid2), .key_code(key_code2), .key_ext(key_ext2),
    .key_break(key_break2), .key_repeat(key_repeat2), .key_held(key_held2),
    .ascii(ascii2), .key_count(key_count2), .err_ovf(err_ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] ref_ascii(input logic [7:0] code);
    logic [7:0] codes [36];
    string      chars;
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
              8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    chars = "abcdefghijklmnopqrstuvwxyz0123456789";
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
    for (int i = 0; i < 36; i++)
      if (codes[i] == code) return chars[i];
    return 8'h00;
  endfunction

  task automatic fifo_refresh();
    kb_ready = (fifo.size() != 0);
    kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // Receiver FIFO: the pop strobe is low for a whole cycle, so sample it mid-cycle.
  always @(negedge clk) begin
    if (kb_nextdata_n === 1'b0 && fifo.size() != 0) begin
      void'(fifo.pop_front());
      fifo_refresh();
    end
  end

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00; m_count = 0;
    exp_q.delete();
  endtask

  task automatic model_feed(input logic [7:0] b);
    ev_t e;
    logic same;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b != 8'hE1) begin
      same  = m_held && (m_hcode == b) && (m_hext == m_ext);
      e.code = b; e.ext = m_ext; e.brk = m_brk; e.rep = 0;
      if (m_brk) begin
        if (same) m_held = 0;
      end else if (same) begin
        e.rep = 1;
      end else begin
        m_held = 1; m_hcode = b; m_hext = m_ext; m_count++;
      end
      e.held  = m_held;
      e.asc   = (m_held && !m_hext) ? ref_ascii(m_hcode) : 8'h00;
      e.count = m_count;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
    fifo_refresh();
    model_feed(b);
  endtask

  // Event monitor: every key_valid pulse must match the next predicted event.
  always @(negedge clk) begin
    ev_t e;
    if (clrn === 1'b1 && key_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_event got code=%h ext=%b brk=%b required none", key_code, key_ext, key_break);
      end else begin
        e = exp_q.pop_front();
        if ({key_code, key_ext, key_break, key_repeat} !== {e.code, e.ext, e.brk, e.rep}) begin
          bad++;
          $display("[TB] FAIL event_fields got code=%h ext=%b brk=%b rep=%b required code=%h ext=%b brk=%b rep=%b",
                   key_code, key_ext, key_break, key_repeat, e.code, e.ext, e.brk, e.rep);
        end
        total++;
        if ({key_held, ascii} !== {e.held, e.asc}) begin
          bad++;
          $display("[TB] FAIL held_ascii got held=%b ascii=%h required held=%b ascii=%h", key_held, ascii, e.held, e.asc);
        end
        total++;
        if (key_count !== 8'(e.count)) begin
          bad++;
          $display("[TB] FAIL key_count got %0d required %0d", key_count, 8'(e.count));
        end
        total++;
        if (key_count2 !== 2'(e.count)) begin
          bad++;
          $display("[TB] FAIL key_count_w2 got %0d required %0d", key_count2, 2'(e.count));
        end
      end
      total++;
      if ({prev_valid, kb_nextdata_n} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL valid_pulse got prev_valid=%b nextdata_n=%b required 0 0", prev_valid, kb_nextdata_n);
      end
    end
    prev_valid = (clrn === 1'b1) ? key_valid : 1'b0;
  end

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    kb_overflow = 1'b0;
    fifo.delete();
    fifo_refresh();
    model_reset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (n >= 400 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got fifo=%0d pending_events=%0d required 0 0", fifo.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({kb_nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat, key_held, ascii, key_count, err_ovf}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_state got nd=%b v=%b code=%h ext=%b brk=%b rep=%b held=%b ascii=%h cnt=%0d ovf=%b required idle zeros",
               kb_nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat, key_held, ascii, key_count, err_ovf);
    end
  endtask

  task automatic test_single_make();
    do_reset();
    send(8'h1C);
    drain();
    total++;
    if ({key_code, key_break, key_held, ascii, key_count} !== {8'h1C, 1'b0, 1'b1, 8'h61, 8'd1}) begin
      bad++;
      $display("[TB] FAIL single_make got code=%h brk=%b held=%b ascii=%h cnt=%0d required 1c 0 1 61 1",
               key_code, key_break, key_held, ascii, key_count);
    end
  endtask

  task automatic test_repeat_break();
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    total++;
    if ({key_count, key_break, key_repeat, key_held, ascii} !== {8'd1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("[TB] FAIL repeat_break got cnt=%0d brk=%b rep=%b held=%b ascii=%h required 1 1 0 0 00",
               key_count, key_break, key_repeat, key_held, ascii);
    end
  endtask

  task automatic test_ext_break();
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE1);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'hF0); send(8'h32);
    drain();
    total++;
    if ({key_held, key_count, ascii} !== {1'b0, 8'd1, 8'h00}) begin
      bad++;
      $display("[TB] FAIL ext_break got held=%b cnt=%0d ascii=%h required 0 1 00", key_held, key_count, ascii);
    end
  endtask

  task automatic test_back_to_back();
    int pops[$];
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kb_nextdata_n === 1'b0) pops.push_back(cyc);
    end
    total++;
    if (pops.size() != 4) begin
      bad++;
      $display("[TB] FAIL pop_count got %0d required 4", pops.size());
    end
    for (int i = 1; i < pops.size(); i++) begin
      total++;
      if (pops[i] - pops[i-1] != 3) begin
        bad++;
        $display("[TB] FAIL pop_spacing got %0d required 3", pops[i] - pops[i-1]);
      end
    end
    drain();
  endtask

  task automatic test_overflow_reset();
    int n = 0;
    do_reset();
    @(negedge clk); kb_overflow = 1'b1;
    @(negedge clk); kb_overflow = 1'b0;
    send(8'h29);
    drain();
    total++;
    if ({err_ovf, ascii} !== {1'b1, 8'h20}) begin
      bad++;
      $display("[TB] FAIL ovf_sticky got ovf=%b ascii=%h required 1 20", err_ovf, ascii);
    end
    fifo.push_back(8'hE0);
    fifo_refresh();
    while (kb_nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    clrn = 1'b0;
    fifo.delete();
    fifo_refresh();
    model_reset();
    @(negedge clk);
    total++;
    if (n >= 20 || {kb_nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat, key_held, key_count, err_ovf}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("[TB] FAIL ack_reset got waited=%0d nd=%b v=%b code=%h ext=%b brk=%b rep=%b held=%b cnt=%0d ovf=%b required idle zeros",
               n, kb_nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat, key_held, key_count, err_ovf);
    end
    clrn = 1'b1;
    send(8'h1C);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    drain();
    total++;
    if ({key_count2, key_count} !== {2'd1, 8'd5}) begin
      bad++;
      $display("[TB] FAIL count_wrap got w2=%0d w8=%0d required 1 5", key_count2, key_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12];
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h1C, 8'h1C, 8'h32, 8'h29, 8'h5A, 8'h75, 8'h45, 8'h12, 8'h1C};
    do_reset();
    for (int i = 0; i < 80; i++) begin
      send(pool[$urandom_range(11)]);
      if ($urandom_range(3) == 0) repeat ($urandom_range(6)) @(negedge clk);
      while (fifo.size() > 4) @(negedge clk);
    end
    drain();
    total++;
    if ({key_held, key_count, ascii} !== {m_held, 8'(m_count), (m_held && !m_hext) ? ref_ascii(m_hcode) : 8'h00}) begin
      bad++;
      $display("[TB] FAIL random_final got held=%b cnt=%0d ascii=%h required held=%b cnt=%0d",
               key_held, key_count, ascii, m_held, 8'(m_count));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_make();
    test_repeat_break();
    test_ext_break();
    test_back_to_back();
    test_overflow_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_scan_ctrl.md
KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the make-event counter.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: clrn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: kb_data  input  8  scan byte at the head of the keyboard receiver FIFO.
REQ-005 SHALL have port: kb_ready  input  1  receiver FIFO non-empty.
REQ-006 SHALL have port: kb_overflow  input  1  receiver FIFO overflow flag.
REQ-007 SHALL have port: kb_nextdata_n  output  1  active-low pop strobe to receiver.
REQ-008 SHALL have port: key_valid  output  1  one-cycle pulse, a complete key event is presented.
REQ-009 SHALL have port: key_code  output  8  final scan byte of the last event.
REQ-010 SHALL have port: key_ext  output  1  last event carried an E0 prefix.
REQ-011 SHALL have port: key_break  output  1  last event was a release (F0 prefix).
REQ-012 SHALL have port: key_repeat  output  1  last event was a typematic repeat of the held key.
REQ-013 SHALL have port: key_held  output  1  a key is currently held.
REQ-014 SHALL have port: ascii  output  8  ASCII of held key_code, 0x00 if unmapped or none held.
REQ-015 SHALL have port: key_count  output  CNT_W  count of non-repeat make events.
REQ-016 SHALL have port: err_ovf  output  1  sticky receiver-overflow indicator.

Function
REQ-017 SHALL implement FSM IDLE, ACK, GAP; IDLE->ACK on edge where kb_ready=1 (byte captured), ACK->GAP, GAP->IDLE unconditionally.
REQ-018 SHALL drive kb_nextdata_n=0 only in ACK, exactly one cycle per captured byte; throughput max one byte per 3 cycles.
REQ-019 SHALL never capture while in ACK or GAP, regardless of kb_ready.
REQ-020 SHALL decode captured byte at the IDLE->ACK edge: 0xE0 sets ext flag; 0xF0 sets brk flag; 0xE1 dropped, no flag change; any other byte is terminal.
REQ-021 SHALL on terminal byte: load key_code, key_ext=ext flag, key_break=brk flag, pulse key_valid=1 during ACK, then clear both flags.
REQ-022 SHALL treat repeated prefixes (F0 F0, E0 E0) as idempotent flag sets.
REQ-023 SHALL track one held key {ext,code}: non-break terminal matching held key -> key_repeat=1, key_count unchanged; else key_repeat=0, held:={ext,code}, key_held=1, key_count+1.
REQ-024 SHALL on break terminal matching held key clear key_held; break of non-held key emits event, held state unchanged; key_repeat=0 for all breaks.
REQ-025 SHALL wrap key_count modulo 2^CNT_W without error.
REQ-026 SHALL hold key_code/key_ext/key_break/key_repeat stable between events; key_valid 0 outside ACK.
REQ-027 SHALL set err_ovf on any cycle kb_overflow=1; clears only at reset.
REQ-028 SHALL derive ascii combinationally from held key_code when key_held=1 and ext=0; else 0x00.

Reset
REQ-029 SHALL on clrn=0 at an edge: state IDLE, flags, held key, key_count, err_ovf, key_code, key_ext, key_break, key_repeat, key_held, key_valid all 0; kb_nextdata_n=1.
REQ-030 SHALL on reset asserted in ACK abort the pop (kb_nextdata_n=1 next cycle) with no event emitted.

Structure
REQ-031 SHALL place prefix constants (E0, F0, E1) and FSM state encoding in shared package kbd_pkg.
REQ-032 SHALL instantiate one sub-module kbd_scan2ascii: combinational set-2 scan code to ASCII lookup (letters, digits, space, enter).

Verification
REQ-033 SHALL cover: FIFO bytes 1C -> one key_valid, key_code=1C, break=0, key_count=1, ascii=0x61.
REQ-034 SHALL cover: 1C,1C,1C,F0,1C -> count=1, repeat=1 on events 2-3, final break=1, key_held=0.
REQ-035 SHALL cover: E0,F0,75 -> single event code=75, ext=1, break=1; E0/F0 produce no key_valid.
REQ-036 SHALL cover: kb_ready held high with 4 queued bytes -> kb_nextdata_n low one cycle every 3 cycles, 4 pops.
REQ-037 SHALL cover: kb_overflow pulse 1 cycle -> err_ovf=1 until clrn=0; clrn=0 during ACK -> no event, all outputs reset.
REQ-038 SHALL cover: CNT_W=2, 5 distinct makes -> key_count=1 after wrap.
